// File: rtl/reaction_timer_ctrl_pkg.sv
// Shared types and defaults for the reaction-time trial controller.
package reaction_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DELAY, REACT, DONE} state_e;

  localparam int DELAY_W_DFLT    = 14;
  localparam int TIMEOUT_MS_DFLT = 9999;
  localparam logic [DELAY_W_DFLT-1:0] BEST_NONE = '1;
endpackage

// File: rtl/reaction_timer_ctrl_ms_tick_gen.sv
// Millisecond prescaler: one-cycle Tick every CLK_PER_MS cycles, restarted by Clr.
module ms_tick_gen #(
  parameter int CLK_PER_MS = 1000
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Clr,
  output logic Tick
);
  localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (Clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Tick = (cnt_q == LAST) && !Clr;
endmodule

// File: rtl/reaction_timer_ctrl.sv
// One reaction-time trial: random wait, stimulus LED, ms-resolution reaction count.
// Define REACTION_BEST_EN to track the best (minimum) valid reaction in BestMs.
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int CLK_PER_MS = 1000,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DFLT,
  parameter int DELAY_W    = DELAY_W_DFLT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [DELAY_W-1:0] DelayMs,
  input  logic               Button,
  output logic               Led,
  output logic               Busy,
  output logic [DELAY_W-1:0] ReactionMs,
  output logic               Valid,
  output logic               Cheat,
  output logic               Timeout,
  output logic [DELAY_W-1:0] BestMs
);
  localparam logic [DELAY_W-1:0] TO_V = DELAY_W'(TIMEOUT_MS);
  localparam logic [DELAY_W-1:0] ONE  = DELAY_W'(1);

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] dly_q, dly_d, rx_q, rx_d, reaction_q, reaction_d, rx_inc;
  logic               valid_q, valid_d, cheat_q, cheat_d, tmo_q, tmo_d;
  logic               btn_q, press, tick, start_acc;

  assign start_acc = Start && (state_q == IDLE || state_q == DONE);
  assign press     = Button && !btn_q;
  assign rx_inc    = rx_q + ONE;

  ms_tick_gen #(.CLK_PER_MS(CLK_PER_MS)) u_tick (
    .Clk  (Clk),
    .Rst  (Rst),
    .Clr  (start_acc),
    .Tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    rx_d       = rx_q;
    reaction_d = reaction_q;
    cheat_d    = cheat_q;
    tmo_d      = tmo_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d    = WAIT_DELAY;
          dly_d      = DelayMs;
          cheat_d    = 1'b0;
          tmo_d      = 1'b0;
          reaction_d = '0;
        end
      end
      WAIT_DELAY: begin
        // A press on the same cycle as the final tick still counts as a cheat.
        if (press) begin
          state_d    = DONE;
          cheat_d    = 1'b1;
          reaction_d = '0;
          valid_d    = 1'b1;
        end else if (tick) begin
          if (dly_q <= ONE) begin
            state_d = REACT;
            rx_d    = '0;
          end else begin
            dly_d = dly_q - ONE;
          end
        end
      end
      REACT: begin
        if (press) begin
          state_d    = DONE;
          reaction_d = rx_q;
          valid_d    = 1'b1;
        end else if (tick) begin
          rx_d = rx_inc;
          if (rx_inc == TO_V) begin
            state_d    = DONE;
            tmo_d      = 1'b1;
            reaction_d = TO_V;
            valid_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      rx_q       <= '0;
      reaction_q <= '0;
      valid_q    <= 1'b0;
      cheat_q    <= 1'b0;
      tmo_q      <= 1'b0;
      btn_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      rx_q       <= rx_d;
      reaction_q <= reaction_d;
      valid_q    <= valid_d;
      cheat_q    <= cheat_d;
      tmo_q      <= tmo_d;
      btn_q      <= Button;
    end
  end

  assign Led        = (state_q == REACT);
  assign Busy       = (state_q == WAIT_DELAY) || (state_q == REACT);
  assign ReactionMs = reaction_q;
  assign Valid      = valid_q;
  assign Cheat      = cheat_q;
  assign Timeout    = tmo_q;

`ifdef REACTION_BEST_EN
  logic [DELAY_W-1:0] best_q;

  always_ff @(posedge Clk) begin
    if (Rst)
      best_q <= {DELAY_W{1'b1}};
    else if (valid_q && !cheat_q && !tmo_q && reaction_q < best_q)
      best_q <= reaction_q;
  end

  assign BestMs = best_q;
`else
  assign BestMs = {DELAY_W{1'b1}};
`endif
endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Scoreboard bench for reaction_timer_ctrl with a trial-level timing model.
module tb_reaction_timer_ctrl;
  localparam int CPM = 10;
  localparam int TO  = 40;
  localparam int W   = 14;

  logic         Clk = 1'b0;
  logic         Rst, Start, Button;
  logic [W-1:0] DelayMs;
  logic         Led, Busy, Valid, Cheat, Timeout;
  logic [W-1:0] ReactionMs, BestMs;

  always #5 Clk = ~Clk;

  reaction_timer_ctrl #(.CLK_PER_MS(CPM), .TIMEOUT_MS(TO), .DELAY_W(W)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .DelayMs    (DelayMs),
    .Button     (Button),
    .Led        (Led),
    .Busy       (Busy),
    .ReactionMs (ReactionMs),
    .Valid      (Valid),
    .Cheat      (Cheat),
    .Timeout    (Timeout),
    .BestMs     (BestMs)
  );

  typedef struct {
    logic [W-1:0] rx;
    logic         cheat;
    logic         tmo;
    logic [W-1:0] best;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_fail = 0;
  logic [W-1:0] m_best = '1;
  logic         best_pend = 1'b0;
  logic [W-1:0] best_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: every Valid pulse must match the oldest outstanding trial.
  always @(negedge Clk) begin
    exp_t e;
    if (best_pend) begin
      check("best_ms", BestMs, best_exp);
      best_pend = 1'b0;
    end
    if (Valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("reaction_ms", ReactionMs, e.rx);
        check("cheat", Cheat, e.cheat);
        check("timeout", Timeout, e.tmo);
        best_pend = 1'b1;
        best_exp  = e.best;
      end
    end
  end

  // e: press edge in cycles after the Start edge (0 = never). inj: -1 random, 0 none.
  task automatic run_trial(input int d, input int e, input bit held, input int inj, input int rst_at);
    int   wait_c, end_c, led_rise, inj_k;
    exp_t x;
    wait_c = CPM * ((d < 2) ? 1 : d);
    x.cheat = 1'b0;
    x.tmo   = 1'b0;
    if (held) e = 0;
    if (e > 0 && e <= wait_c) begin
      x.cheat = 1'b1;
      x.rx    = '0;
      end_c   = e;
    end else if (e > 0 && e <= wait_c + CPM * TO) begin
      x.rx  = W'((e - wait_c - 1) / CPM);
      end_c = e;
    end else begin
      x.tmo = 1'b1;
      x.rx  = W'(TO);
      end_c = wait_c + CPM * TO;
    end
`ifdef REACTION_BEST_EN
    if (!x.cheat && !x.tmo && x.rx < m_best) m_best = x.rx;
`endif
    x.best = m_best;
    if (rst_at == 0) sb.push_back(x);

    inj_k = inj;
    if (inj < 0) inj_k = (end_c > 3) ? $urandom_range(2, end_c - 1) : 0;

    if (held) begin
      Button = 1'b1;
      step();
    end
    Start   = 1'b1;
    DelayMs = W'(d);
    step();
    Start   = 1'b0;
    DelayMs = W'($urandom);
    led_rise = -1;
    for (int k = 1; k <= end_c + 1; k++) begin
      if (k == e) Button = 1'b1;
      if (k == inj_k) begin
        Start   = 1'b1;
        DelayMs = W'(1);
      end
      if (k == rst_at) Rst = 1'b1;
      step();
      Start = 1'b0;
      if (Led && led_rise < 0) led_rise = k;
      if (k == rst_at) begin
        Rst = 1'b0;
        m_best = '1;
        check("rst_led", Led, 0);
        check("rst_busy", Busy, 0);
        check("rst_valid", Valid, 0);
        check("rst_rx", ReactionMs, 0);
        check("rst_best", BestMs, 16383);
        break;
      end
    end
    if (rst_at == 0) check("led_rise_cycle", led_rise, x.cheat ? -1 : wait_c);
    Button = 1'b0;
    repeat ($urandom_range(2, 5)) step();
  endtask

  initial begin
    bit led_seen;
    int d, mode, wc, e;
    Rst = 1'b1; Start = 1'b0; Button = 1'b0; DelayMs = '0;
    repeat (3) step();
    Rst = 1'b0;
    led_seen = 1'b0;
    repeat (50) begin
      step();
      if (Led) led_seen = 1'b1;
    end
    check("idle_led_seen", led_seen, 0);
    check("idle_busy", Busy, 0);
    check("idle_valid", Valid, 0);
    check("idle_cheat", Cheat, 0);
    check("idle_timeout", Timeout, 0);
    check("idle_rx", ReactionMs, 0);
    check("idle_best", BestMs, 16383);

    run_trial(3, 0, 0, 0, 0);                 // timeout
    run_trial(2, 20 + 55, 0, 0, 0);           // 5 ms
    run_trial(2, 20 + 75, 0, 0, 0);           // 7
    run_trial(1, 10 + 45, 0, 0, 0);           // 4
    run_trial(1000, 100, 0, 0, 0);            // cheat, Led never
    run_trial(3, 30 + 95, 0, 0, 0);           // 9
    run_trial(2, 0, 1, 0, 0);                 // held button: no cheat
    run_trial(4, 40 + 33, 0, 15, 0);          // Start during WAIT_DELAY
    run_trial(2, 20 + 64, 0, 30, 0);          // Start during REACT
    run_trial(0, 10, 0, 0, 0);                // press with final tick: cheat
    run_trial(1, 11, 0, 0, 0);                // first REACT cycle: 0 ms
    run_trial(1, 10 + CPM * TO, 0, 0, 0);     // press beats timeout tick
    run_trial(2, 0, 0, 0, 35);                // reset mid-REACT

    for (int i = 0; i < 25; i++) begin
      d    = $urandom_range(0, 6);
      wc   = CPM * ((d < 2) ? 1 : d);
      mode = $urandom_range(0, 9);
      if (mode == 2)      e = $urandom_range(1, wc);
      else if (mode > 2)  e = wc + $urandom_range(1, CPM * TO + 5);
      else                e = 0;
      run_trial(d, e, mode == 1, ($urandom_range(0, 1) == 1) ? -1 : 0, 0);
    end

    repeat (5) step();
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/reaction_timer_ctrl.md
Name: reaction_timer_ctrl

Overview:
Consumes the 14-bit pseudo-random delay (ms, range 1000..3000) from the random-value generator and runs one reaction-time trial. It waits the delay, lights the stimulus LED, and measures the ms until the player presses the button. It flags early presses (cheat) and no-press timeouts. Results go to the score/display stage.

Parameters:
CLK_PER_MS, 1000, Clk cycles per millisecond tick (set 10 in simulation)
TIMEOUT_MS, 9999, reaction count ceiling in ms; must fit 14 bits
DELAY_W, 14, width of delay and result values

Ports:
Clk  in  1  system clock
Rst  in  1  synchronous, active-high reset
Start  in  1  one-cycle pulse; begins a trial; samples DelayMs
DelayMs  in  DELAY_W  wait before stimulus, in ms
Button  in  1  player button, already synchronised/debounced, level
Led  out  1  stimulus light; high only in REACT
Busy  out  1  high in WAIT_DELAY or REACT
ReactionMs  out  DELAY_W  measured reaction time; held until next Start
Valid  out  1  one-cycle pulse when a trial ends (any outcome)
Cheat  out  1  sticky: trial ended by a press during WAIT_DELAY
Timeout  out  1  sticky: trial ended with no press within TIMEOUT_MS
BestMs  out  DELAY_W  best valid reaction (see Optional Feature)

Behaviour:
- Reset: state IDLE. Led=0, Busy=0, Valid=0, Cheat=0, Timeout=0, ReactionMs=0, BestMs=all-ones. Prescaler and counters cleared. Reset mid-trial aborts immediately with no Valid.
- ms tick: the prescaler counts 0..CLK_PER_MS-1 and emits a one-cycle tick on wrap. Start clears it, so the first tick arrives CLK_PER_MS cycles after Start.
- Button edge: registered copy of Button; press = Button & ~Button_q. A button held across Start does not count as a press.
- IDLE/DONE: Start -> WAIT_DELAY. DlyCnt <= DelayMs. Cheat, Timeout, ReactionMs cleared. Busy=1 from the next cycle.
- WAIT_DELAY:
  - press -> DONE with Cheat=1, ReactionMs=0, Valid pulse.
  - else on tick: if DlyCnt<=1 -> REACT, else decrement DlyCnt.
  - DelayMs=0 or 1 therefore both give a 1 ms wait.
  - Press takes priority over a simultaneous tick.
- REACT:
  - Led=1; RxCnt is cleared on entry.
  - press -> DONE with ReactionMs=RxCnt (pre-increment value if a tick coincides), Valid pulse.
  - else on tick: RxCnt+1. If the new value == TIMEOUT_MS -> DONE, Timeout=1, ReactionMs=TIMEOUT_MS, Valid pulse.
- DONE: Led=0, Busy=0. Outputs held. Start begins a new trial.
- Start while Busy is ignored.
- All arithmetic is unsigned DELAY_W bits; counters never wrap.

Optional Feature:
Macro REACTION_BEST_EN.
- Defined: BestMs tracks the minimum ReactionMs over non-cheat, non-timeout trials since reset. It updates in the same cycle as Valid (visible the next cycle). All-ones means no valid trial yet.
- Undefined: BestMs is tied constant to all-ones and no comparator is built.

Decomposition:
- Package reaction_pkg: state enum (IDLE, WAIT_DELAY, REACT, DONE), DELAY_W default, TIMEOUT_MS default, BEST_NONE all-ones constant.
- Sub-module ms_tick_gen (params CLK_PER_MS; ports Clk, Rst, Clr, Tick) holds the prescaler.

Test Plan:
All scenarios use CLK_PER_MS=10.
- Reset, then idle 50 cycles -> all outputs at reset values, Led never high.
- Start with DelayMs=3, no press -> Led rises 30 cycles after Start, ±1 cycle of FSM latency; then Timeout=1, ReactionMs=9999, single Valid.
- DelayMs=2, press 55 cycles after Led rises -> ReactionMs=5, Cheat=0, Valid once, Led falls the next cycle.
- DelayMs=1000, press at cycle 100 -> Cheat=1, ReactionMs=0, Led never rises. Button held high before Start and through the wait -> no cheat.
- Start asserted during WAIT_DELAY and during REACT -> ignored, trial timing unchanged. Rst asserted mid-REACT -> IDLE next cycle, no Valid.
- REACTION_BEST_EN defined: trials giving 7, 4, a cheat, then 9 -> BestMs reads 7, 4, 4, 4. Undefined -> BestMs=16383 throughout.
